// File: rtl/traffic_light_monitor.sv
// Passive checker/decoder for the traffic-light lamp and 7-segment outputs.
// Define TL_MON_SEG_CHECK_EN to build the 7-segment decode and its checks.
module traffic_light_monitor #(
  parameter int unsigned T_RED         = 10,
  parameter int unsigned T_RED_YELLOW  = 3,
  parameter int unsigned T_GREEN       = 10,
  parameter int unsigned T_GREEN_BLINK = 8,
  parameter int unsigned T_YELLOW      = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       red_light,
  input  logic       yellow_light,
  input  logic       green_light,
  input  logic [6:0] seven_seg,
  output logic [2:0] phase,
  output logic [3:0] digit,
  output logic       digit_valid,
  output logic       phase_done,
  output logic [4:0] phase_len,
  output logic [7:0] cycle_count,
  output logic       seq_error,
  output logic [2:0] err_code,
  output logic [7:0] err_count
);

  localparam logic [2:0] PH_IDLE        = 3'd0;
  localparam logic [2:0] PH_RED         = 3'd1;
  localparam logic [2:0] PH_RED_YELLOW  = 3'd2;
  localparam logic [2:0] PH_GREEN       = 3'd3;
  localparam logic [2:0] PH_GREEN_BLINK = 3'd4;
  localparam logic [2:0] PH_YELLOW      = 3'd5;

  localparam logic [2:0] L_DARK       = 3'b000;
  localparam logic [2:0] L_GREEN      = 3'b001;
  localparam logic [2:0] L_YELLOW     = 3'b010;
  localparam logic [2:0] L_RED        = 3'b100;
  localparam logic [2:0] L_RED_YELLOW = 3'b110;

  localparam logic [4:0] CNT_MAX  = 5'd31;
  localparam logic [7:0] BYTE_MAX = 8'd255;
  localparam logic [4:0] T_RED_L  = 5'(T_RED);

  function automatic logic [4:0] expected_len(input logic [2:0] ph);
    case (ph)
      PH_RED:         expected_len = 5'(T_RED);
      PH_RED_YELLOW:  expected_len = 5'(T_RED_YELLOW);
      PH_GREEN:       expected_len = 5'(T_GREEN);
      PH_GREEN_BLINK: expected_len = 5'(T_GREEN_BLINK);
      PH_YELLOW:      expected_len = 5'(T_YELLOW);
      default:        expected_len = 5'd0;
    endcase
  endfunction

  // Returns {valid, value}; segment order is {g,f,e,d,c,b,a}, blank encodes 0.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    case (seg)
      7'b0000000: seg_decode = {1'b1, 4'd0};
      7'b0000110: seg_decode = {1'b1, 4'd1};
      7'b1011011: seg_decode = {1'b1, 4'd2};
      7'b1001111: seg_decode = {1'b1, 4'd3};
      7'b1100110: seg_decode = {1'b1, 4'd4};
      7'b1101101: seg_decode = {1'b1, 4'd5};
      7'b1111101: seg_decode = {1'b1, 4'd6};
      7'b0000111: seg_decode = {1'b1, 4'd7};
      7'b1111111: seg_decode = {1'b1, 4'd8};
      7'b1101111: seg_decode = {1'b1, 4'd9};
      default:    seg_decode = {1'b0, 4'd0};
    endcase
  endfunction

  function automatic logic [2:0] first_code(input logic [6:1] errs);
    if (errs[1]) begin
      first_code = 3'd1;
    end else if (errs[2]) begin
      first_code = 3'd2;
    end else if (errs[3]) begin
      first_code = 3'd3;
    end else if (errs[4]) begin
      first_code = 3'd4;
    end else if (errs[5]) begin
      first_code = 3'd5;
    end else if (errs[6]) begin
      first_code = 3'd6;
    end else begin
      first_code = 3'd0;
    end
  endfunction

  logic [2:0] phase_r;
  logic [4:0] cnt_r;
  logic       resync_r;
  logic [2:0] last_lamp_r;
  logic [3:0] digit_r;
  logic       digit_valid_r;
  logic       phase_done_r;
  logic [4:0] phase_len_r;
  logic [7:0] cycle_count_r;
  logic       seq_error_r;
  logic [2:0] err_code_r;
  logic [7:0] err_count_r;

  logic [2:0] lamp_s;
  logic       lamp_illegal_s;
  logic [2:0] next_phase_s;
  logic       seq_err_s;
  logic       phase_change_s;
  logic       phase_exit_s;
  logic       legal_exit_s;
  logic [4:0] cnt_next_s;
  logic [6:1] err_s;
  logic       any_err_s;
  logic [3:0] seg_digit_s;
  logic       seg_valid_s;
  logic       seg_bad_s;
  logic       seg_count_err_s;

  assign lamp_s         = {red_light, yellow_light, green_light};
  assign lamp_illegal_s = (lamp_s == 3'b011) || (lamp_s == 3'b101) || (lamp_s == 3'b111);

  // Phase sequencer: legal stays/advances, anything else drops to IDLE.
  always_comb begin
    next_phase_s = PH_IDLE;
    seq_err_s    = 1'b0;
    if (lamp_illegal_s) begin
      next_phase_s = PH_IDLE;
    end else begin
      case (phase_r)
        PH_IDLE: begin
          if (lamp_s == L_RED) next_phase_s = PH_RED;
          else                 next_phase_s = PH_IDLE;
        end
        PH_RED: begin
          if (lamp_s == L_RED)             next_phase_s = PH_RED;
          else if (lamp_s == L_RED_YELLOW) next_phase_s = PH_RED_YELLOW;
          else                             seq_err_s    = 1'b1;
        end
        PH_RED_YELLOW: begin
          if (lamp_s == L_RED_YELLOW) next_phase_s = PH_RED_YELLOW;
          else if (lamp_s == L_GREEN) next_phase_s = PH_GREEN;
          else                        seq_err_s    = 1'b1;
        end
        PH_GREEN: begin
          if (lamp_s == L_GREEN)     next_phase_s = PH_GREEN;
          else if (lamp_s == L_DARK) next_phase_s = PH_GREEN_BLINK;
          else                       seq_err_s    = 1'b1;
        end
        PH_GREEN_BLINK: begin
          if ((lamp_s == L_DARK) || (lamp_s == L_GREEN)) next_phase_s = PH_GREEN_BLINK;
          else if (lamp_s == L_YELLOW)                   next_phase_s = PH_YELLOW;
          else                                           seq_err_s    = 1'b1;
        end
        PH_YELLOW: begin
          if (lamp_s == L_YELLOW)   next_phase_s = PH_YELLOW;
          else if (lamp_s == L_RED) next_phase_s = PH_RED;
          else                      seq_err_s    = 1'b1;
        end
        default: next_phase_s = PH_IDLE;
      endcase
    end
  end

  // Phase count of the current sample: 1 on entry, saturating increment on stay.
  always_comb begin
    phase_change_s = (next_phase_s != phase_r);
    phase_exit_s   = phase_change_s && (phase_r != PH_IDLE);
    legal_exit_s   = phase_exit_s && !lamp_illegal_s && !seq_err_s;
    if (phase_change_s) begin
      cnt_next_s = 5'd1;
    end else if (cnt_r == CNT_MAX) begin
      cnt_next_s = CNT_MAX;
    end else begin
      cnt_next_s = cnt_r + 5'd1;
    end
  end

`ifdef TL_MON_SEG_CHECK_EN
  logic [4:0] seg_dec_s;
  logic [4:0] countdown_exp_s;

  // Digit decode and countdown check; counts beyond T_RED expect a steady 0.
  always_comb begin
    seg_dec_s   = seg_decode(seven_seg);
    seg_valid_s = seg_dec_s[4];
    seg_digit_s = seg_dec_s[3:0];
    seg_bad_s   = !seg_dec_s[4];
    if (cnt_next_s <= T_RED_L) begin
      countdown_exp_s = T_RED_L - cnt_next_s;
    end else begin
      countdown_exp_s = 5'd0;
    end
    if (!seg_dec_s[4]) begin
      seg_count_err_s = 1'b0;
    end else if (next_phase_s == PH_RED) begin
      seg_count_err_s = !resync_r && ({1'b0, seg_dec_s[3:0]} != countdown_exp_s);
    end else begin
      seg_count_err_s = (seg_dec_s[3:0] != 4'd0);
    end
  end
`else
  logic unused_seg_s;
  assign unused_seg_s = ^seven_seg;

  // Segment checking is not built: constant-off decode.
  always_comb begin
    seg_valid_s     = 1'b0;
    seg_digit_s     = 4'd0;
    seg_bad_s       = 1'b0;
    seg_count_err_s = 1'b0;
  end
`endif

  // Error vector for this sample, indexed by error code.
  always_comb begin
    err_s[1]  = lamp_illegal_s;
    err_s[2]  = seq_err_s;
    err_s[3]  = legal_exit_s && !resync_r && (cnt_r != expected_len(phase_r));
    err_s[4]  = (phase_r == PH_GREEN_BLINK) && (next_phase_s == PH_GREEN_BLINK) &&
                (lamp_s == last_lamp_r);
    err_s[5]  = seg_count_err_s;
    err_s[6]  = seg_bad_s;
    any_err_s = |err_s;
  end

  // State, statistics and sticky error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_r       <= PH_IDLE;
      cnt_r         <= 5'd0;
      resync_r      <= 1'b1;
      last_lamp_r   <= 3'b000;
      digit_r       <= 4'd0;
      digit_valid_r <= 1'b0;
      phase_done_r  <= 1'b0;
      phase_len_r   <= 5'd0;
      cycle_count_r <= 8'd0;
      seq_error_r   <= 1'b0;
      err_code_r    <= 3'd0;
      err_count_r   <= 8'd0;
    end else begin
      phase_r       <= next_phase_s;
      cnt_r         <= cnt_next_s;
      last_lamp_r   <= lamp_s;
      digit_r       <= seg_digit_s;
      digit_valid_r <= seg_valid_s;
      phase_done_r  <= phase_exit_s;
      // Resync covers IDLE and the first phase entered from it.
      if (next_phase_s == PH_IDLE) begin
        resync_r <= 1'b1;
      end else if (legal_exit_s) begin
        resync_r <= 1'b0;
      end
      if (phase_exit_s) begin
        phase_len_r <= cnt_r;
      end
      if ((phase_r == PH_YELLOW) && (next_phase_s == PH_RED)) begin
        cycle_count_r <= cycle_count_r + 8'd1;
      end
      if (any_err_s && !seq_error_r) begin
        seq_error_r <= 1'b1;
        err_code_r  <= first_code(err_s);
      end
      if (any_err_s && (err_count_r != BYTE_MAX)) begin
        err_count_r <= err_count_r + 8'd1;
      end
    end
  end

  assign phase       = phase_r;
  assign digit       = digit_r;
  assign digit_valid = digit_valid_r;
  assign phase_done  = phase_done_r;
  assign phase_len   = phase_len_r;
  assign cycle_count = cycle_count_r;
  assign seq_error   = seq_error_r;
  assign err_code    = err_code_r;
  assign err_count   = err_count_r;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Self-checking bench for traffic_light_monitor: directed scenarios plus
// randomized lamp/segment streams compared with a table-driven reference model.
module tb_traffic_light_monitor;

`ifdef TL_MON_SEG_CHECK_EN
  localparam bit SEG_EN = 1'b1;
`else
  localparam bit SEG_EN = 1'b0;
`endif
  localparam int T_RED = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       red_light = 1'b0, yellow_light = 1'b0, green_light = 1'b0;
  logic [6:0] seven_seg = 7'h00;
  logic [2:0] phase;
  logic [3:0] digit;
  logic       digit_valid;
  logic       phase_done;
  logic [4:0] phase_len;
  logic [7:0] cycle_count;
  logic       seq_error;
  logic [2:0] err_code;
  logic [7:0] err_count;

  traffic_light_monitor dut (
    .clk(clk), .rst(rst),
    .red_light(red_light), .yellow_light(yellow_light), .green_light(green_light),
    .seven_seg(seven_seg),
    .phase(phase), .digit(digit), .digit_valid(digit_valid),
    .phase_done(phase_done), .phase_len(phase_len), .cycle_count(cycle_count),
    .seq_error(seq_error), .err_code(err_code), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Lamp code that enters each phase (index = phase), nominal durations, digit patterns.
  int enter_code[6] = '{-1, 4, 6, 1, 0, 2};
  int dur[6]        = '{0, 10, 3, 10, 8, 3};
  int seg_pat[10]   = '{'h00, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};
  int exp_lens[10]  = '{10, 3, 10, 8, 3, 10, 3, 10, 8, 3};

  int checks = 0;
  int errors = 0;
  int len_q[$];

  int m_phase, m_cnt, m_resync, m_last, m_len, m_done, m_cycles;
  int m_seq, m_code, m_ecount, m_digit, m_valid;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s at t=%0t: observed %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_cnt = 0; m_resync = 1; m_last = 0; m_len = 0; m_done = 0;
    m_cycles = 0; m_seq = 0; m_code = 0; m_ecount = 0; m_digit = 0; m_valid = 0;
  endtask

  task automatic model_step(input int l, input int s);
    int np, n, d, nxt, exp_d;
    bit ill, chg, lex, valid;
    bit [6:1] e;
    e = '0;
    ill = (l == 3) || (l == 5) || (l == 7);
    nxt = (m_phase == 5) ? 1 : m_phase + 1;
    if (ill) begin np = 0; e[1] = 1'b1; end
    else if (m_phase == 0) np = (l == 4) ? 1 : 0;
    else if (l == enter_code[m_phase] || (m_phase == 4 && l == 1)) np = m_phase;
    else if (l == enter_code[nxt]) np = nxt;
    else begin np = 0; e[2] = 1'b1; end
    chg = (np != m_phase);
    n = chg ? 1 : ((m_cnt >= 31) ? 31 : m_cnt + 1);
    lex = chg && (m_phase != 0) && !ill && !e[2];
    if (lex && !m_resync && m_cnt != dur[m_phase]) e[3] = 1'b1;
    if (m_phase == 4 && np == 4 && l == m_last) e[4] = 1'b1;
    valid = 1'b0; d = 0;
    for (int k = 0; k < 10; k++) if (s == seg_pat[k]) begin valid = 1'b1; d = k; end
    exp_d = (n <= T_RED) ? T_RED - n : 0;
    if (SEG_EN) begin
      if (!valid) e[6] = 1'b1;
      else if (np == 1) begin if (!m_resync && d != exp_d) e[5] = 1'b1; end
      else if (d != 0) e[5] = 1'b1;
    end
    m_done = (chg && m_phase != 0) ? 1 : 0;
    if (m_done == 1) m_len = m_cnt;
    if (m_phase == 5 && np == 1) m_cycles = (m_cycles + 1) % 256;
    if (np == 0) m_resync = 1; else if (lex) m_resync = 0;
    if (e != 0) begin
      if (m_seq == 0) begin
        m_seq = 1;
        for (int k = 6; k >= 1; k--) if (e[k]) m_code = k;
      end
      if (m_ecount < 255) m_ecount++;
    end
    m_valid = (SEG_EN && valid) ? 1 : 0;
    m_digit = (SEG_EN && valid) ? d : 0;
    m_cnt = n; m_phase = np; m_last = l;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".phase"}, phase, m_phase);
    chk({tag, ".digit"}, digit, m_digit);
    chk({tag, ".digit_valid"}, digit_valid, m_valid);
    chk({tag, ".phase_done"}, phase_done, m_done);
    chk({tag, ".phase_len"}, phase_len, m_len);
    chk({tag, ".cycle_count"}, cycle_count, m_cycles);
    chk({tag, ".seq_error"}, seq_error, m_seq);
    chk({tag, ".err_code"}, err_code, m_code);
    chk({tag, ".err_count"}, err_count, m_ecount);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    {red_light, yellow_light, green_light} = 3'b000;
    seven_seg = 7'h00;
    @(posedge clk);
    model_reset();
    #1;
    check_all("rst");
    rst = 1'b0;
  endtask

  task automatic step(input int l, input int s);
    {red_light, yellow_light, green_light} = 3'(l);
    seven_seg = 7'(s);
    @(posedge clk);
    model_step(l, s);
    #1;
    if (phase_done === 1'b1) len_q.push_back(int'(phase_len));
    check_all("step");
  endtask

  // Nominal lamps for one phase; blink alternates D,G and RED counts down.
  task automatic phase_run(input int p, input int len);
    int lamp, dg;
    for (int i = 1; i <= len; i++) begin
      lamp = (p == 4) ? ((i % 2 == 1) ? 0 : 1) : enter_code[p];
      dg = (p == 1 && i <= T_RED) ? T_RED - i : 0;
      step(lamp, seg_pat[dg]);
    end
  endtask

  task automatic full_loop();
    for (int p = 1; p <= 5; p++) phase_run(p, dur[p]);
  endtask

  initial begin
    do_reset();
    chk("reset_phase", phase, 3'd0);

    // Nominal: two complete loops.
    step(0, 0); step(2, 0); step(0, 0); step(2, 0); step(0, 0); step(2, 0);
    len_q.delete();
    full_loop();
    phase_run(1, 10);
    chk("cycle_count_1", cycle_count, 8'd1);
    for (int p = 2; p <= 5; p++) phase_run(p, dur[p]);
    step(4, seg_pat[9]);
    chk("cycle_count_2", cycle_count, 8'd2);
    chk("nominal_no_error", seq_error, 1'b0);
    chk("len_count", len_q.size(), 10);
    for (int k = 0; k < 10; k++) chk("len_seq", len_q[k], exp_lens[k]);

    // GREEN followed by YELLOW (reset lands mid-RED).
    do_reset();
    step(0, 0); phase_run(1, 10); phase_run(2, 3); phase_run(3, 5);
    step(2, 0);
    chk("g2y_seq_error", seq_error, 1'b1);
    chk("g2y_code", err_code, 3'd2);
    chk("g2y_phase", phase, 3'd0);

    // Checked RED held 11 samples.
    do_reset();
    step(0, 0); full_loop(); phase_run(1, 11);
    chk("red11_no_err_yet", seq_error, 1'b0);
    step(6, 0);
    chk("red11_len", phase_len, 5'd11);
    chk("red11_code", err_code, 3'd3);

    // Illegal lamps in GREEN, then short resync RED.
    do_reset();
    step(0, 0); phase_run(1, 10); phase_run(2, 3); phase_run(3, 4);
    step(5, 0);
    chk("ill_code", err_code, 3'd1);
    chk("ill_phase", phase, 3'd0);
    phase_run(1, 4); step(6, 0); step(6, 0);
    chk("resync_err_count", err_count, 8'd1);

    // Blink stuck on green.
    do_reset();
    step(0, 0); phase_run(1, 10); phase_run(2, 3); phase_run(3, 10);
    step(0, 0); step(1, 0); step(1, 0);
    chk("blink_code", err_code, 3'd4);
    chk("blink_phase", phase, 3'd4);

    // Countdown repeats a digit in a checked RED.
    do_reset();
    step(0, 0); full_loop();
    step(4, seg_pat[9]); step(4, seg_pat[8]);
    chk("cd_ok_so_far", seq_error, 1'b0);
    step(4, seg_pat[8]);
    chk("cd_code", err_code, SEG_EN ? 3'd5 : 3'd0);

    // Illegal segment pattern.
    do_reset();
    step(0, 'h71);
    chk("seg_code", err_code, SEG_EN ? 3'd6 : 3'd0);
    chk("seg_valid", digit_valid, 1'b0);
    chk("seg_digit", digit, 4'd0);

    // Randomized loops with jittered durations and sparse faults.
    do_reset();
    for (int it = 0; it < 12; it++) begin
      if (it == 6) do_reset();
      if ($urandom_range(0, 2) == 0)
        for (int i = 0; i < int'($urandom_range(1, 4)); i++) step(int'($urandom_range(0, 2)), 0);
      for (int p = 1; p <= 5; p++) begin
        int len;
        len = dur[p];
        if ($urandom_range(0, 4) == 0) len = len + int'($urandom_range(0, 2)) - 1;
        for (int i = 1; i <= len; i++) begin
          int lamp, sg;
          lamp = (p == 4) ? ((i % 2 == 1) ? 0 : 1) : enter_code[p];
          sg = seg_pat[(p == 1 && i <= T_RED) ? T_RED - i : 0];
          if ($urandom_range(0, 60) == 0) lamp = int'($urandom_range(0, 7));
          if ($urandom_range(0, 60) == 0) sg = int'($urandom_range(0, 127));
          step(lamp, sg);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_light_monitor.md
# traffic_light_monitor

Passive checker and decoder for the traffic-light output interface: lamp outputs red/yellow/green plus the 7-segment countdown. It samples the lamps every clock and reconstructs the controller phase. It checks phase order, phase durations, blink pattern and countdown digits, and reports a sticky first-error code plus statistics. It sits beside the traffic-light controller in the top level and in the test harness, on the same clock.

## Interface
Parameters (durations in clock cycles):
- T_RED, 10, expected RED length; must be ≤ 10 for the countdown check
- T_RED_YELLOW, 3, expected RED_YELLOW length
- T_GREEN, 10, expected GREEN length
- T_GREEN_BLINK, 8, expected GREEN_BLINK length
- T_YELLOW, 3, expected YELLOW length

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous reset, active-high
- red_light  in  1  red lamp
- yellow_light  in  1  yellow lamp
- green_light  in  1  green lamp
- seven_seg  in  7  segment bits {g,f,e,d,c,b,a}
- phase  out  3  decoded phase: 0 IDLE, 1 RED, 2 RED_YELLOW, 3 GREEN, 4 GREEN_BLINK, 5 YELLOW
- digit  out  4  decoded 7-segment value
- digit_valid  out  1  seven_seg matched a legal pattern on the last sample
- phase_done  out  1  one-cycle pulse when a phase is left
- phase_len  out  5  length of the phase just left, saturating at 31
- cycle_count  out  8  completed YELLOW→RED cycles, wraps at 255
- seq_error  out  1  sticky, set on the first error
- err_code  out  3  code of the first error, held until reset
- err_count  out  8  number of cycles flagged with ≥1 error, saturating at 255

## Operation
- Lamp code L={r,y,g}: 100 R, 110 RY, 001 G, 010 Y, 000 D (dark). Codes 011, 101 and 111 are illegal (error 1) and force the FSM to IDLE.
- FSM, per sample:
  - IDLE: 100 → RED; any other legal code → stay.
  - RED: R → stay; RY → RED_YELLOW; else error 2.
  - RED_YELLOW: RY → stay; G → GREEN; else error 2.
  - GREEN: G → stay; D → GREEN_BLINK; else error 2.
  - GREEN_BLINK: D or G → stay; Y → YELLOW; else error 2.
  - YELLOW: Y → stay; R → RED and cycle_count+1; else error 2.
  - Error 2 → IDLE.
- Phase counter: set to 1 on phase entry, +1 per stay, saturating at 31. On exit, phase_len is loaded with the count and phase_done pulses.
- Duration check (error 3): count ≠ the phase's T_* at exit. Skipped for IDLE and for the first phase entered from IDLE (resync flag).
- Blink check (error 4): in GREEN_BLINK, two consecutive identical samples.
- Seven-seg decode:
  - Legal patterns: 0=0000000, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
  - Any other pattern gives error 6, digit=0, digit_valid=0.
- Countdown check (error 5):
  - In RED, the sample with new phase count n must show T_RED−n.
  - Outside RED, the digit must be 0.
  - Skipped in the resync RED phase.
- Multiple errors on the same edge: lowest code is latched into err_code; err_count increments once.
- Duration, blink and countdown errors do not alter FSM flow.

## Timing
- All outputs are registered and reflect inputs sampled at the previous rising edge (latency 1).
- Reset values:
  - phase=0 (IDLE), resync flag=1.
  - digit=0, digit_valid=0, phase_done=0, phase_len=0, cycle_count=0.
  - seq_error=0, err_code=0, err_count=0.
- Reset asserted mid-sequence: all state cleared on that edge. The next R sample re-enters RED under resync.
- phase_done, phase_len and error flags update on the same edge as the transition to the new phase.

## Configuration
- TL_MON_SEG_CHECK_EN defined: seven-seg decode, digit/digit_valid, and errors 5 and 6 are implemented.
- Undefined: decode logic is removed. digit=0 and digit_valid=0 constantly; errors 5 and 6 are never raised; lamp checks are unchanged.

## Test plan
- Nominal run from reset: IDLE samples D,Y,D,Y,D,Y, then RED×10 (digits 9..0), RY×3, G×10, GB D/G alternating ×8, Y×3, then R. Required: no error. The RED×10 is the resync phase, so its length and countdown are not checked. The first fully checked RED is the one re-entered after YELLOW: drive a second full loop and require no error there too. phase_len sequence 10,3,10,8,3; cycle_count=1 after the first YELLOW→RED, 2 after the second.
- GREEN (001) directly followed by 010 → seq_error=1, err_code=2, phase=0 next cycle.
- RED held 11 cycles, checked phase → at the RED→RY edge: phase_len=11, err_code=3.
- Lamps 101 during GREEN → err_code=1, phase=IDLE. Then a RED of 4 cycles → no additional error (resync); err_count=1.
- Two consecutive 001 samples in GREEN_BLINK → err_code=4, phase remains 4.
- Checked RED showing 9,8,8 → err_code=5 on the third sample. Separately, seven_seg=1110001 → err_code=6, digit_valid=0. With TL_MON_SEG_CHECK_EN undefined, both stimuli give no error and digit=0.
